// File: rtl/soc_ctrl_domain_seq.sv
// Power-up/power-down sequencer for NUM_DOMAINS clock/reset domains: waits for PLL lock,
// enables the clock, holds reset for a programmable delay, and reverses on shutdown.
module soc_ctrl_domain_seq #(
  parameter int NUM_DOMAINS = 5,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         ref_clk_i,
  input  logic                         glb_arst_i,
  input  logic [NUM_DOMAINS-1:0]       dom_en_i,
  input  logic                         seq_mode_i,
  input  logic [NUM_DOMAINS-1:0]       pll_locked_i,
  input  logic [NUM_DOMAINS*CNT_W-1:0] delay_cfg_i,
  input  logic [NUM_DOMAINS-1:0]       err_clr_i,
  output logic [NUM_DOMAINS-1:0]       clk_en_o,
  output logic [NUM_DOMAINS-1:0]       arst_n_o,
  output logic [NUM_DOMAINS-1:0]       ready_o,
  output logic [NUM_DOMAINS-1:0]       err_o,
  output logic                         busy_o
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT_LOCK,
    ST_CLK_ON,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [SYNC_STAGES-1:0][NUM_DOMAINS-1:0] r_lockSync;
  logic [NUM_DOMAINS-1:0]                  w_lockS;
  logic [NUM_DOMAINS-1:0]                  w_effEn;
  logic [NUM_DOMAINS-1:0]                  w_busyVec;
  logic                                    w_chain;

  always_ff @(posedge ref_clk_i or posedge glb_arst_i) begin
    if (glb_arst_i) begin
      r_lockSync <= '0;
    end else begin
      r_lockSync[0] <= pll_locked_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_lockSync[s] <= r_lockSync[s-1];
      end
    end
  end

  assign w_lockS = r_lockSync[SYNC_STAGES-1];

  // In ordered mode a domain is only enabled while every lower domain is requested too.
  always_comb begin
    w_effEn = '0;
    w_chain = 1'b1;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      w_chain    = w_chain & dom_en_i[i];
      w_effEn[i] = seq_mode_i ? w_chain : dom_en_i[i];
    end
  end

  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
    state_t           r_state;
    state_t           w_stateNxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNxt;
    logic [CNT_W-1:0] w_load;
    logic             w_errSet;
    logic             w_depOk;
    logic             w_upOff;
    logic             r_err;
    logic             r_clkEn;
    logic             r_arstN;
    logic             r_ready;
    logic             r_busy;

    assign w_load = (delay_cfg_i[i*CNT_W +: CNT_W] == '0) ? CntOne
                                                          : delay_cfg_i[i*CNT_W +: CNT_W];

    // Ordered mode: bring up after the lower neighbour runs, shut down after the upper one is gated.
    if (i == 0) begin : g_depFirst
      assign w_depOk = 1'b1;
    end else begin : g_depChain
      assign w_depOk = ~seq_mode_i | ready_o[i-1];
    end

    if (i == NUM_DOMAINS - 1) begin : g_upLast
      assign w_upOff = 1'b1;
    end else begin : g_upChain
      assign w_upOff = ~seq_mode_i | ~clk_en_o[i+1];
    end

    always_comb begin
      w_stateNxt = r_state;
      w_cntNxt   = r_cnt;
      w_errSet   = 1'b0;
      unique case (r_state)
        ST_OFF: begin
          if (w_effEn[i]) w_stateNxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (!w_effEn[i]) begin
            w_stateNxt = ST_OFF;
          end else if (w_lockS[i] && w_depOk) begin
            w_stateNxt = ST_CLK_ON;
            w_cntNxt   = w_load;
          end
        end
        ST_CLK_ON: begin
          if (!w_lockS[i]) begin
            w_errSet   = 1'b1;
            w_stateNxt = w_effEn[i] ? ST_WAIT_LOCK : ST_OFF;
          end else if (!w_effEn[i]) begin
            w_stateNxt = ST_DRAIN;
            w_cntNxt   = w_load;
          end else if (r_cnt == CntOne) begin
            w_stateNxt = ST_RUN;
          end else begin
            w_cntNxt = r_cnt - CntOne;
          end
        end
        ST_RUN: begin
          if (!w_lockS[i]) begin
            w_errSet   = 1'b1;
            w_stateNxt = w_effEn[i] ? ST_WAIT_LOCK : ST_OFF;
          end else if (!w_effEn[i] && w_upOff) begin
            w_stateNxt = ST_DRAIN;
            w_cntNxt   = w_load;
          end
        end
        ST_DRAIN: begin
          if (!w_lockS[i]) begin
            w_errSet   = 1'b1;
            w_stateNxt = w_effEn[i] ? ST_WAIT_LOCK : ST_OFF;
          end else if (r_cnt == CntOne) begin
            w_stateNxt = ST_OFF;
          end else begin
            w_cntNxt = r_cnt - CntOne;
          end
        end
        default: w_stateNxt = ST_OFF;
      endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge ref_clk_i or posedge glb_arst_i) begin
      if (glb_arst_i) begin
        r_state <= ST_OFF;
        r_cnt   <= '0;
        r_err   <= 1'b0;
        r_clkEn <= 1'b0;
        r_arstN <= 1'b0;
        r_ready <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_stateNxt;
        r_cnt   <= w_cntNxt;
        r_err   <= w_errSet | (r_err & ~err_clr_i[i]);
        r_clkEn <= (w_stateNxt == ST_CLK_ON) || (w_stateNxt == ST_RUN) || (w_stateNxt == ST_DRAIN);
        r_arstN <= (w_stateNxt == ST_RUN);
        r_ready <= (w_stateNxt == ST_RUN);
        r_busy  <= (w_stateNxt == ST_WAIT_LOCK) || (w_stateNxt == ST_CLK_ON) ||
                   (w_stateNxt == ST_DRAIN);
      end
    end

    assign clk_en_o[i]  = r_clkEn;
    assign arst_n_o[i]  = r_arstN;
    assign ready_o[i]   = r_ready;
    assign err_o[i]     = r_err;
    assign w_busyVec[i] = r_busy;
  end

  assign busy_o = |w_busyVec;

endmodule

// File: tb/tb_soc_ctrl_domain_seq.sv
// Scoreboard bench for soc_ctrl_domain_seq: stimulus queues hand-computed output events,
// a negedge monitor pops one whenever the observed outputs change.
module tb_soc_ctrl_domain_seq;

  logic        ref_clk_i = 1'b0;
  logic        glb_arst_i;
  logic [4:0]  dom_en_i;
  logic        seq_mode_i;
  logic [4:0]  pll_locked_i;
  logic [39:0] delay_cfg_i;
  logic [4:0]  err_clr_i;
  logic [4:0]  clk_en_o;
  logic [4:0]  arst_n_o;
  logic [4:0]  ready_o;
  logic [4:0]  err_o;
  logic        busy_o;

  soc_ctrl_domain_seq #(
    .NUM_DOMAINS(5),
    .CNT_W(8),
    .SYNC_STAGES(2)
  ) dut (
    .ref_clk_i(ref_clk_i),
    .glb_arst_i(glb_arst_i),
    .dom_en_i(dom_en_i),
    .seq_mode_i(seq_mode_i),
    .pll_locked_i(pll_locked_i),
    .delay_cfg_i(delay_cfg_i),
    .err_clr_i(err_clr_i),
    .clk_en_o(clk_en_o),
    .arst_n_o(arst_n_o),
    .ready_o(ready_o),
    .err_o(err_o),
    .busy_o(busy_o)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  typedef struct {
    int         cyc;
    logic [4:0] clk;
    logic [4:0] rst;
    logic [4:0] err;
    logic       busy;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   base = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  logic monActive = 1'b0;
  logic [15:0] prevSnap = '0;

  always @(posedge ref_clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Output changes only ever come from the monitor popping the scoreboard.
  always @(negedge ref_clk_i) begin
    logic [15:0] snap;
    exp_t        e;
    snap = {clk_en_o, arst_n_o, err_o, busy_o};
    if (monActive && snap !== prevSnap) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedEvent", int'(snap), int'(prevSnap));
      end else begin
        e = expQ.pop_front();
        checkOutput("evCycle", cyc, e.cyc);
        checkOutput("evClkEn", int'(clk_en_o), int'(e.clk));
        checkOutput("evArstN", int'(arst_n_o), int'(e.rst));
        checkOutput("evReady", int'(ready_o), int'(e.rst));
        checkOutput("evErr", int'(err_o), int'(e.err));
        checkOutput("evBusy", int'(busy_o), int'(e.busy));
      end
    end
    prevSnap = snap;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge ref_clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] en, input logic [4:0] lock);
    dom_en_i     = en;
    pll_locked_i = lock;
    base         = cyc;
  endtask

  task automatic pushExp(input int dc, input logic [4:0] c, input logic [4:0] r,
                         input logic [4:0] e, input logic b);
    expQ.push_back('{base + dc, c, r, e, b});
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  initial begin
    glb_arst_i   = 1'b1;
    dom_en_i     = '0;
    seq_mode_i   = 1'b0;
    pll_locked_i = 5'b11111;
    delay_cfg_i  = '0;
    err_clr_i    = '0;
    #2;
    checkOutput("rstClkEn", int'(clk_en_o), 0);
    checkOutput("rstArstN", int'(arst_n_o), 0);
    checkOutput("rstReady", int'(ready_o), 0);
    checkOutput("rstErr", int'(err_o), 0);
    checkOutput("rstBusy", int'(busy_o), 0);
    waitCycles(2);
    glb_arst_i = 1'b0;
    waitCycles(5);
    monActive = 1'b1;

    // Independent bring-up with delay 4, then symmetric drain.
    delay_cfg_i = {5{8'd4}};
    applyStimulus(5'b00001, 5'b11111);
    pushExp(1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    pushExp(2, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(6, 5'b00001, 5'b00001, 5'b00000, 1'b0);
    waitCycles(10);
    applyStimulus(5'b00000, 5'b11111);
    pushExp(1, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(5, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    waitCycles(10);
    checkDrained("qEmptyDelay4");

    // Delay 0 behaves like delay 1.
    delay_cfg_i = '0;
    applyStimulus(5'b00001, 5'b11111);
    pushExp(1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    pushExp(2, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(3, 5'b00001, 5'b00001, 5'b00000, 1'b0);
    waitCycles(6);
    applyStimulus(5'b00000, 5'b11111);
    pushExp(1, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(2, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    waitCycles(6);
    checkDrained("qEmptyDelay0");

    // Ordered mode: ascending bring-up, descending shutdown, delay 2.
    seq_mode_i  = 1'b1;
    delay_cfg_i = {5{8'd2}};
    applyStimulus(5'b11111, 5'b11111);
    pushExp(1,  5'b00000, 5'b00000, 5'b00000, 1'b1);
    pushExp(2,  5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(4,  5'b00001, 5'b00001, 5'b00000, 1'b1);
    pushExp(5,  5'b00011, 5'b00001, 5'b00000, 1'b1);
    pushExp(7,  5'b00011, 5'b00011, 5'b00000, 1'b1);
    pushExp(8,  5'b00111, 5'b00011, 5'b00000, 1'b1);
    pushExp(10, 5'b00111, 5'b00111, 5'b00000, 1'b1);
    pushExp(11, 5'b01111, 5'b00111, 5'b00000, 1'b1);
    pushExp(13, 5'b01111, 5'b01111, 5'b00000, 1'b1);
    pushExp(14, 5'b11111, 5'b01111, 5'b00000, 1'b1);
    pushExp(16, 5'b11111, 5'b11111, 5'b00000, 1'b0);
    waitCycles(20);
    applyStimulus(5'b11110, 5'b11111);
    pushExp(1,  5'b11111, 5'b01111, 5'b00000, 1'b1);
    pushExp(3,  5'b01111, 5'b01111, 5'b00000, 1'b0);
    pushExp(4,  5'b01111, 5'b00111, 5'b00000, 1'b1);
    pushExp(6,  5'b00111, 5'b00111, 5'b00000, 1'b0);
    pushExp(7,  5'b00111, 5'b00011, 5'b00000, 1'b1);
    pushExp(9,  5'b00011, 5'b00011, 5'b00000, 1'b0);
    pushExp(10, 5'b00011, 5'b00001, 5'b00000, 1'b1);
    pushExp(12, 5'b00001, 5'b00001, 5'b00000, 1'b0);
    pushExp(13, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(15, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    waitCycles(20);
    applyStimulus(5'b00000, 5'b11111);
    seq_mode_i = 1'b0;
    waitCycles(3);
    checkDrained("qEmptyOrdered");

    // Lock loss in RUN with enable held, relock, then clear the sticky error.
    applyStimulus(5'b00001, 5'b11111);
    pushExp(1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    pushExp(2, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(4, 5'b00001, 5'b00001, 5'b00000, 1'b0);
    waitCycles(8);
    applyStimulus(5'b00001, 5'b11110);
    pushExp(3, 5'b00000, 5'b00000, 5'b00001, 1'b1);
    waitCycles(6);
    applyStimulus(5'b00001, 5'b11111);
    pushExp(3, 5'b00001, 5'b00000, 5'b00001, 1'b1);
    pushExp(5, 5'b00001, 5'b00001, 5'b00001, 1'b0);
    waitCycles(8);
    applyStimulus(5'b00001, 5'b11111);
    err_clr_i = 5'b00001;
    pushExp(1, 5'b00001, 5'b00001, 5'b00000, 1'b0);
    waitCycles(1);
    err_clr_i = '0;
    waitCycles(5);
    applyStimulus(5'b00000, 5'b11111);
    pushExp(1, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    pushExp(3, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    waitCycles(6);
    checkDrained("qEmptyLockLoss");

    // Asynchronous reset in the middle of CLK_ON.
    delay_cfg_i = {5{8'd10}};
    applyStimulus(5'b00001, 5'b11111);
    pushExp(1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    pushExp(2, 5'b00001, 5'b00000, 5'b00000, 1'b1);
    waitCycles(3);
    checkDrained("qEmptyPreReset");
    monActive = 1'b0;
    #2;
    glb_arst_i = 1'b1;
    #1;
    checkOutput("midRstClkEn", int'(clk_en_o), 0);
    checkOutput("midRstArstN", int'(arst_n_o), 0);
    checkOutput("midRstReady", int'(ready_o), 0);
    checkOutput("midRstBusy", int'(busy_o), 0);
    dom_en_i = '0;
    waitCycles(2);
    glb_arst_i = 1'b0;
    pll_locked_i = 5'b11110;
    waitCycles(3);
    monActive = 1'b1;

    // Enable dropped while still waiting for lock: back to OFF without a clock pulse.
    applyStimulus(5'b00001, 5'b11110);
    pushExp(1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    waitCycles(3);
    applyStimulus(5'b00000, 5'b11110);
    pushExp(1, 5'b00000, 5'b00000, 5'b00000, 1'b0);
    waitCycles(8);
    checkDrained("qEmptyWaitDrop");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
